// File: rtl/div_reconstruct.sv
// Rebuilds the dividend N = Q*D + R with a radix-2 signed shift-add multiplier behind valid/ready handshakes.
// Optional compare against n_exp when DIV_RECON_CHECK_EN is defined; otherwise mismatch is tied low.
module div_reconstruct #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     d,
    input  logic [WIDTH-1:0]     r,
    input  logic [2*WIDTH-1:0]   n_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   n_out,
    output logic                 mismatch,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      q_reg;
    logic [WIDTH-1:0]      d_reg;
    logic [WIDTH-1:0]      r_reg;
    logic [2*WIDTH-1:0]    acc;
    logic [CW-1:0]         cnt;
    logic [2*WIDTH-1:0]    d_ext;
    logic [2*WIDTH-1:0]    d_shift;
    logic [2*WIDTH-1:0]    r_ext;
    logic                  last_bit;

    assign d_ext    = {{WIDTH{d_reg[WIDTH-1]}}, d_reg};
    assign r_ext    = {{WIDTH{r_reg[WIDTH-1]}}, r_reg};
    assign d_shift  = d_ext << cnt;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)              state_nxt = MUL;
            MUL:  if (last_bit)              state_nxt = ADD;
            ADD:                             state_nxt = DONE;
            DONE: if (out_valid && out_ready) state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // The sign bit of q carries weight -2^(W-1), hence the subtract on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            n_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_reg <= q;
                        d_reg <= d;
                        r_reg <= r;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                MUL: begin
                    if (q_reg[cnt]) begin
                        if (last_bit) acc <= acc - d_shift;
                        else          acc <= acc + d_shift;
                    end
                    cnt <= cnt + 1'b1;
                end
                ADD: acc <= acc + r_ext;
                DONE: begin
                    if (!out_valid) begin
                        n_out     <= acc;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_RECON_CHECK_EN
    logic [2*WIDTH-1:0] n_exp_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_exp_reg <= '0;
            mismatch  <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) n_exp_reg <= n_exp;
            if (state == DONE && !out_valid) mismatch <= (acc != n_exp_reg);
        end
    end
`else
    logic unused_n_exp;
    assign unused_n_exp = ^n_exp;
    assign mismatch     = 1'b0;
`endif

endmodule
